// File: rtl/rstatus_writeback_unit_pkg.sv
// rstatus_writeback_unit_pkg: shared cause/kind encodings, rstatus codes and decode helper
package rstatus_writeback_unit_pkg;
   typedef enum logic [1:0] {CAUSE_NONE = 2'd0, CAUSE_ADD = 2'd1, CAUSE_ADDI = 2'd2, CAUSE_SUB = 2'd3} cause_e;
   typedef enum logic {KIND_EXC = 1'b0, KIND_SETX = 1'b1} kind_e;
   localparam logic [31:0] CODE_ADD = 32'd1;
   localparam logic [31:0] CODE_ADDI = 32'd2;
   localparam logic [31:0] CODE_SUB = 32'd3;
   localparam int RSTATUS_REG_IDX = 30;
   function automatic cause_e decode_cause(input logic [31:0] code);
      return code == CODE_ADD ? CAUSE_ADD : code == CODE_ADDI ? CAUSE_ADDI : code == CODE_SUB ? CAUSE_SUB : CAUSE_NONE;
   endfunction
endpackage

// File: rtl/rstatus_writeback_unit_stage_reg.sv
// rstatus_stage_reg: valid/kind/val pipeline entry with stall hold and bubble load
module rstatus_stage_reg
   import rstatus_writeback_unit_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        ld_v,
   input  logic        ld_kind,
   input  logic [31:0] ld_val,
   output logic        v_q,
   output logic        kind_q,
   output logic [31:0] val_q
);
   logic        v_d;
   logic        kind_d;
   logic [31:0] val_d;
   // hold the entry while stalled, otherwise take the upstream entry (ld_v=0 loads a bubble)
   always_comb begin
      v_d = stall ? v_q : ld_v;
      kind_d = stall ? kind_q : ld_kind;
      val_d = stall ? val_q : ld_val;
   end
   // entry register; reset drops whatever is in flight
   always_ff @(posedge clock) begin
      if (!reset) begin
         v_q <= 1'b0;
         kind_q <= KIND_EXC;
         val_q <= '0;
      end else begin
         v_q <= v_d;
         kind_q <= kind_d;
         val_q <= val_d;
      end
   end
endmodule

// File: rtl/rstatus_writeback_unit.sv
// rstatus_writeback_unit: carries rstatus/setx values X->M->W, redirects writeback to $r30, tracks cause and count
module rstatus_writeback_unit
   import rstatus_writeback_unit_pkg::*;
#(
   parameter int RSTATUS_REG = RSTATUS_REG_IDX,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             x_exc,
   input  logic [31:0]      x_exc_code,
   input  logic             x_setx,
   input  logic [26:0]      x_target,
   input  logic [4:0]       w_rd_in,
   input  logic [31:0]      w_data_in,
   input  logic             w_we_in,
   output logic [4:0]       wb_rd,
   output logic [31:0]      wb_data,
   output logic             wb_we,
   output logic [31:0]      rstatus_q,
   output logic [31:0]      rstatus_fwd,
   output logic             exc_pending,
   output logic [1:0]       cause_q,
   output logic [CNT_W-1:0] exc_count
);
   logic             x_v, x_kind, m_v, m_kind, w_v, w_kind, retire;
   logic [31:0]      x_val, m_val, w_val, rstatus_d;
   logic [1:0]       cause_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // X-side entry: exception wins over setx, flush turns it into a bubble
   always_comb begin
      x_v = !flush && (x_exc || x_setx);
      x_kind = x_exc ? KIND_EXC : KIND_SETX;
      x_val = x_exc ? x_exc_code : {5'b0, x_target};
   end
   rstatus_stage_reg u_m (
      .clock(clock), .reset(reset), .stall(stall),
      .ld_v(x_v), .ld_kind(x_kind), .ld_val(x_val),
      .v_q(m_v), .kind_q(m_kind), .val_q(m_val)
   );
   rstatus_stage_reg u_w (
      .clock(clock), .reset(reset), .stall(stall),
      .ld_v(m_v), .ld_kind(m_kind), .ld_val(m_val),
      .v_q(w_v), .kind_q(w_kind), .val_q(w_val)
   );
   // retirement is the M->W move of a valid entry; only then do status, cause and count change
   always_comb begin
      retire = !stall && m_v;
      rstatus_d = retire ? m_val : rstatus_q;
      cause_d = (retire && m_kind == KIND_EXC) ? decode_cause(m_val) : cause_q;
      cnt_d = (retire && m_kind == KIND_EXC && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;
   end
   // architectural status state
   always_ff @(posedge clock) begin
      if (!reset) begin
         rstatus_q <= '0;
         cause_q <= CAUSE_NONE;
         cnt_q <= '0;
      end else begin
         rstatus_q <= rstatus_d;
         cause_q <= cause_d;
         cnt_q <= cnt_d;
      end
   end
   // writeback steering and youngest-value forwarding for bex
   always_comb begin
      wb_rd = w_v ? 5'(RSTATUS_REG) : w_rd_in;
      wb_data = w_v ? w_val : w_data_in;
      wb_we = w_v || w_we_in;
      rstatus_fwd = m_v ? m_val : w_v ? w_val : rstatus_q;
      exc_pending = m_v || w_v;
   end
   assign exc_count = cnt_q;
endmodule
